apb_gpio_irq: RTL and testbench

Parametrised APB3 GPIO peripheral for the RISC-V MCU, the successor to the fixed-width GPO/GPI/GPIO blocks. It adds a per-pin direction register, atomic set/clear output writes, synchronised input readback, and per-pin rising/falling edge interrupts with write-1-to-clear status and a single combined interrupt line. The block sits on the MCU APB bus next to the UART. The pad tristate (`gpio = gpio_oe ? gpio_out : 'z`) is instantiated in the MCU top, not in this block.

---
 rtl/apb_gpio_irq.sv | 84 ++++++++
 tb/tb_apb_gpio_irq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_irq.sv
// apb_gpio_irq: APB3 GPIO with direction, atomic set/clear output writes and edge interrupts.
// PADDR carries one bit above the 0x00-0x1C window so that 0x20+ accesses can be flagged with PSLVERR.
module apb_gpio_irq #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       PADDR,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [31:0]      PWDATA,
   output logic [31:0]      PRDATA,
   output logic             PREADY,
   output logic             PSLVERR,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q, dir_q, odr_q, rise_en_q, fall_en_q, status_q;
   logic [WIDTH-1:0] dir_d, odr_d, rise_en_d, fall_en_d, status_d;
   logic [WIDTH-1:0] sync, wd, w1c, rd_w;
   logic [2:0]       a;
   logic             acc, wr, rd, irq_q;
   logic             unused_bits;

   assign acc         = PSEL & PENABLE;
   assign wr          = acc & PWRITE & ~PADDR[5];
   assign rd          = acc & ~PWRITE & ~PADDR[5];
   assign a           = PADDR[4:2];
   assign wd          = PWDATA[WIDTH-1:0];
   assign sync        = sync_q[SYNC_STAGES-1];
   assign unused_bits = ^{PADDR[1:0], PWDATA};

   always_comb begin
      dir_d     = (wr && a == 3'd0) ? wd : dir_q;
      odr_d     = (wr && a == 3'd1) ? wd :
                  (wr && a == 3'd6) ? (odr_q | wd) :
                  (wr && a == 3'd7) ? (odr_q & ~wd) : odr_q;
      rise_en_d = (wr && a == 3'd3) ? wd : rise_en_q;
      fall_en_d = (wr && a == 3'd4) ? wd : fall_en_q;
      w1c       = (wr && a == 3'd5) ? wd : '0;
      // a fresh enabled edge overrides a same-cycle clear of its bit
      status_d  = (status_q & ~w1c) | (sync & ~prev_q & rise_en_q) | (~sync & prev_q & fall_en_q);
      rd_w      = (a == 3'd0) ? dir_q :
                  (a == 3'd1) ? odr_q :
                  (a == 3'd2) ? sync :
                  (a == 3'd3) ? rise_en_q :
                  (a == 3'd4) ? fall_en_q :
                  (a == 3'd5) ? status_q : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         prev_q    <= '0;
         dir_q     <= '0;
         odr_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
         prev_q    <= sync;
         dir_q     <= dir_d;
         odr_q     <= odr_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         irq_q     <= |status_d;
      end
   end

   assign PREADY   = acc;
   assign PSLVERR  = acc & PADDR[5];
   assign PRDATA   = rd ? 32'(rd_w) : 32'd0;
   assign gpio_out = odr_q;
   assign gpio_oe  = dir_q;
   assign irq      = irq_q;
endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb_apb_gpio_irq: directed checks of the APB GPIO register map, edge interrupts and error response.
module tb_apb_gpio_irq;
   logic        clk = 1'b0, reset = 1'b0;
   logic [5:0]  PADDR = '0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PWDATA = '0, PRDATA;
   logic        PREADY, PSLVERR, irq;
   logic [7:0]  gpio_in = '0, gpio_out, gpio_oe;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] rdat;
   logic        rerr;

   apb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apb_write(input logic [5:0] addr, input logic [31:0] data);
      @(negedge clk);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
      @(negedge clk);
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [5:0] addr, output logic [31:0] data, output logic err);
      @(negedge clk);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
      @(negedge clk);
      PENABLE = 1'b1;
      #1;
      data = PRDATA; err = PSLVERR;
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_oe", 32'(gpio_oe), 32'h0);
      check("rst_out", 32'(gpio_out), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_prdata_idle", PRDATA, 32'h0);
      check("rst_pslverr", 32'(PSLVERR), 32'h0);
      for (int i = 0; i < 8; i++) begin
         apb_read(6'(i * 4), rdat, rerr);
         check($sformatf("rst_reg%0d", i), rdat, 32'h0);
      end

      apb_write(6'h00, 32'hFF);
      apb_write(6'h04, 32'h0F);
      apb_write(6'h18, 32'h30);
      apb_write(6'h1C, 32'h03);
      check("gpio_out_setclr", 32'(gpio_out), 32'h3C);
      check("gpio_oe_all", 32'(gpio_oe), 32'hFF);
      apb_read(6'h04, rdat, rerr);
      check("odr_read", rdat, 32'h3C);
      apb_read(6'h18, rdat, rerr);
      check("odr_set_read", rdat, 32'h0);
      check("odr_set_err", 32'(rerr), 32'h0);
      apb_write(6'h00, 32'h1FF);
      apb_read(6'h00, rdat, rerr);
      check("dir_wide", rdat, 32'hFF);

      // rising edge on pin 0, IDR held in an access phase across the sync delay
      apb_write(6'h0C, 32'h01);
      @(negedge clk);
      gpio_in[0] = 1'b1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 6'h08;
      @(negedge clk);
      PENABLE = 1'b1;
      #1;
      check("idr_k", PRDATA, 32'h0);
      check("irq_k", 32'(irq), 32'h0);
      @(negedge clk);
      #1;
      check("idr_k1", PRDATA, 32'h1);
      check("irq_k1", 32'(irq), 32'h0);
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0;
      #1;
      check("irq_k2", 32'(irq), 32'h1);
      apb_read(6'h14, rdat, rerr);
      check("status_rise", rdat, 32'h01);
      apb_write(6'h14, 32'h01);
      #1;
      check("irq_w1c", 32'(irq), 32'h0);
      apb_read(6'h14, rdat, rerr);
      check("status_w1c", rdat, 32'h0);

      gpio_in = 8'hC1;
      idle(4);
      apb_read(6'h14, rdat, rerr);
      check("status_no_en", rdat, 32'h0);
      apb_write(6'h10, 32'h80);
      gpio_in = 8'h01;
      idle(4);
      apb_read(6'h14, rdat, rerr);
      check("status_fall", rdat, 32'h80);
      check("irq_fall", 32'(irq), 32'h1);
      apb_write(6'h0C, 32'h41);
      apb_write(6'h10, 32'hC0);
      idle(3);
      apb_read(6'h14, rdat, rerr);
      check("status_late_en", rdat, 32'h80);
      apb_write(6'h14, 32'h80);
      apb_write(6'h10, 32'h80);

      apb_write(6'h0C, 32'h45);
      gpio_in = 8'h05;
      idle(4);
      apb_read(6'h14, rdat, rerr);
      check("status_pin2", rdat, 32'h04);
      gpio_in = 8'h01;
      idle(4);
      // clear of bit 2 completes on the edge that detects the new rise
      @(negedge clk);
      gpio_in = 8'h05;
      @(negedge clk);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h14; PWDATA = 32'h04;
      @(negedge clk);
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      #1;
      check("irq_race", 32'(irq), 32'h1);
      apb_read(6'h14, rdat, rerr);
      check("status_race", rdat, 32'h04);
      apb_write(6'h14, 32'h04);
      #1;
      check("irq_race_clr", 32'(irq), 32'h0);

      apb_read(6'h24, rdat, rerr);
      check("err_rdata", rdat, 32'h0);
      check("err_pslverr", 32'(rerr), 32'h1);
      apb_write(6'h20, 32'h00);
      apb_write(6'h38, 32'hFF);
      apb_read(6'h00, rdat, rerr);
      check("err_dir_kept", rdat, 32'hFF);
      apb_read(6'h04, rdat, rerr);
      check("err_odr_kept", rdat, 32'h3C);

      @(negedge clk);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h04; PWDATA = 32'hAA;
      @(negedge clk);
      PENABLE = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      apb_read(6'h04, rdat, rerr);
      check("midrst_odr", rdat, 32'h0);
      check("midrst_out", 32'(gpio_out), 32'h0);
      check("midrst_oe", 32'(gpio_oe), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
